axi4l_slave_regbank: RTL and testbench

AXI4L_SLAVE_REGBANK -- requirements
Module: axi4l_slave_regbank

---
 rtl/axi4l_slave_regbank.sv | 179 +++++++++++++++++
 tb/tb_axi4l_slave_regbank.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_slave_regbank.sv
// AXI4-Lite register bank: NUM_REGS registers of DATA_W bits, each either RW (stored)
// or RO (read live from hw_in). Independent write and read channel FSMs.
module axi4l_slave_regbank #(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 12,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic [DATA_W/8-1:0]          WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RVALID,
  input  logic                         RREADY,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  rdy_pre_q, rdy_en_q;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]     w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [IDX_W-1:0]      ar_idx;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  unused_addr_lsbs;

  // Readies stay low until the second edge after reset release.
  assign AWREADY  = rdy_en_q && (wstate_q == W_IDLE || wstate_q == W_GOT_W);
  assign WREADY   = rdy_en_q && (wstate_q == W_IDLE || wstate_q == W_GOT_AW);
  assign ARREADY  = rdy_en_q && (rstate_q == R_IDLE);
  assign BVALID   = (wstate_q == W_RESP);
  assign RVALID   = (rstate_q == R_DATA);
  assign BRESP    = bresp_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign wr_pulse = wr_pulse_q;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign ar_idx = ARADDR[ADDR_W-1:LSB];
  assign unused_addr_lsbs = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wstate_d   = wstate_q;
    aw_idx_d   = aw_idx_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    commit     = 1'b0;

    if (aw_hs) aw_idx_d = AWADDR[ADDR_W-1:LSB];
    if (w_hs) begin
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) commit = 1'b1;
        else if (aw_hs)    wstate_d = W_GOT_AW;
        else if (w_hs)     wstate_d = W_GOT_W;
      end
      W_GOT_AW: if (w_hs)   commit = 1'b1;
      W_GOT_W:  if (aw_hs)  commit = 1'b1;
      W_RESP:   if (BREADY) wstate_d = W_IDLE;
      default:  wstate_d = W_IDLE;
    endcase

    // The _d copies already hold whichever half arrived this cycle.
    if (commit) begin
      wstate_d = W_RESP;
      bresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(aw_idx_d) == i && !RO_MASK[i]) begin
          bresp_d       = RESP_OKAY;
          wr_pulse_d[i] = 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (w_strb_d[k]) regs_d[i][8*k +: 8] = w_data_d[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(ar_idx) == i) begin
              rresp_d = RESP_OKAY;
              rdata_d = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : regs_q[i];
            end
          end
        end
      end
      R_DATA:  if (RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      rdy_pre_q  <= 1'b0;
      rdy_en_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      // NOTE: the register array is architecturally visible, so it is reset, unlike a RAM.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      rdy_pre_q  <= 1'b1;
      rdy_en_q   <= rdy_pre_q;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi4l_slave_regbank.sv
// Self-checking bench for axi4l_slave_regbank: directed vector table, hand-written corner
// sequences, then random traffic against an array-based reference model.
module tb_axi4l_slave_regbank;

  localparam int          DW = 32;
  localparam int          NR = 16;
  localparam logic [15:0] RO_MASK = 16'h8000;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic              ACLK, ARESETN;
  logic [11:0]       AWADDR, ARADDR;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [DW-1:0]     WDATA, RDATA;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP, RRESP;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [NR*DW-1:0]  hw_in, reg_out;
  logic [NR-1:0]     wr_pulse;

  axi4l_slave_regbank #(.DATA_W(DW), .ADDR_W(12), .NUM_REGS(NR), .RO_MASK(RO_MASK)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .hw_in(hw_in), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] model_regs [NR];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [1:0]  resp, m_resp;
  logic [15:0] pulse, m_pulse;
  logic [31:0] rdata, m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference model: registers as a plain array, byte merge via a mask.
  task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] r,
                             output logic [15:0] p);
    int idx;
    logic [31:0] mask;
    idx = int'(addr) / 4;
    p = '0;
    r = SLVERR;
    if (idx < NR) begin
      if (!RO_MASK[idx]) begin
        mask = '0;
        for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
        model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
        p[idx] = 1'b1;
        r = OKAY;
      end
    end
  endtask

  task automatic model_read(input logic [11:0] addr, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(addr) / 4;
    d = '0;
    r = SLVERR;
    if (idx < NR) begin
      r = OKAY;
      d = RO_MASK[idx] ? hw_in[idx*DW +: DW] : model_regs[idx];
    end
  endtask

  task automatic check_reg_out(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_reg_out%0d", tag, i), reg_out[i*DW +: DW],
            RO_MASK[i] ? 32'h0 : model_regs[i]);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] r, output logic [15:0] p);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && n < 50) begin
      AWVALID = !aw_done && (n >= aw_dly);
      WVALID  = !w_done && (n >= w_dly);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      tick();
      n++;
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      if (!(aw_done && w_done)) check("b_early", BVALID, 1'b0);
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("wr_handshake_done", aw_done && w_done, 1'b1);
    check("b_latency", BVALID, 1'b1);
    r = BRESP;
    p = wr_pulse;
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("b_hold_valid", BVALID, 1'b1);
      check("b_hold_resp", BRESP, r);
      check("b_stall_awready", AWREADY, 1'b0);
      check("b_stall_wready", WREADY, 1'b0);
      check("wr_pulse_width", wr_pulse, 16'h0);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("b_release", BVALID, 1'b0);
    check("wr_pulse_clear", wr_pulse, 16'h0);
  endtask

  task automatic do_read(input logic [11:0] addr, input int r_dly,
                         output logic [31:0] d, output logic [1:0] r);
    bit fired;
    int n;
    fired = 0; n = 0;
    ARADDR = addr;
    ARVALID = 1'b1;
    while (!fired && n < 50) begin
      fired = ARREADY;
      tick();
      n++;
    end
    ARVALID = 1'b0;
    check("ar_handshake_done", fired, 1'b1);
    check("r_latency", RVALID, 1'b1);
    d = RDATA;
    r = RRESP;
    for (int i = 0; i < r_dly; i++) begin
      hw_in[15*DW +: DW] = $urandom;
      tick();
      check("r_hold_valid", RVALID, 1'b1);
      check("r_hold_data", RDATA, d);
      check("r_hold_resp", RRESP, r);
      check("r_stall_arready", ARREADY, 1'b0);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("r_release", RVALID, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, AWREADY, 1'b0);
    check({tag, "_wready"}, WREADY, 1'b0);
    check({tag, "_arready"}, ARREADY, 1'b0);
    check({tag, "_bvalid"}, BVALID, 1'b0);
    check({tag, "_rvalid"}, RVALID, 1'b0);
    check({tag, "_wr_pulse"}, wr_pulse, 16'h0);
  endtask

  initial begin
    // NOTE: bench inputs are driven with blocking assignments 1ns after the clock edge.
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0; hw_in = '0;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;

    vecs[0]  = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, OKAY,   32'h0,        16'h0002};
    vecs[1]  = '{1'b0, 12'h004, 32'h0,        4'h0, OKAY,   32'hDEADBEEF, 16'h0};
    vecs[2]  = '{1'b1, 12'h00C, 32'h11223344, 4'hF, OKAY,   32'h0,        16'h0008};
    vecs[3]  = '{1'b1, 12'h00C, 32'hAABBCCDD, 4'h5, OKAY,   32'h0,        16'h0008};
    vecs[4]  = '{1'b0, 12'h00C, 32'h0,        4'h0, OKAY,   32'h11BB33DD, 16'h0};
    vecs[5]  = '{1'b1, 12'h03C, 32'h12345678, 4'hF, SLVERR, 32'h0,        16'h0};
    vecs[6]  = '{1'b1, 12'h040, 32'h87654321, 4'hF, SLVERR, 32'h0,        16'h0};
    vecs[7]  = '{1'b0, 12'h03C, 32'h0,        4'h0, OKAY,   32'h5A5A5A5A, 16'h0};
    vecs[8]  = '{1'b0, 12'h040, 32'h0,        4'h0, SLVERR, 32'h0,        16'h0};
    vecs[9]  = '{1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, OKAY,   32'h0,        16'h0010};
    vecs[10] = '{1'b0, 12'h010, 32'h0,        4'h0, OKAY,   32'h0,        16'h0};
    vecs[11] = '{1'b0, 12'h007, 32'h0,        4'h0, OKAY,   32'hDEADBEEF, 16'h0};
    vecs[12] = '{1'b1, 12'hFFC, 32'h00000001, 4'hF, SLVERR, 32'h0,        16'h0};
    vecs[13] = '{1'b1, 12'h02B, 32'h0000A5A5, 4'h3, OKAY,   32'h0,        16'h0400};
    vecs[14] = '{1'b0, 12'h028, 32'h0,        4'h0, OKAY,   32'h0000A5A5, 16'h0};
    vecs[15] = '{1'b0, 12'h03D, 32'h0,        4'h0, OKAY,   32'h5A5A5A5A, 16'h0};

    // Reset state and ready-enable timing.
    repeat (2) tick();
    check_idle_outputs("reset");
    check("reset_bresp", BRESP, 2'b00);
    check("reset_rresp", RRESP, 2'b00);
    check("reset_rdata", RDATA, 32'h0);
    check_reg_out("reset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    check("rel_edge1_awready", AWREADY, 1'b0);
    check("rel_edge1_wready", WREADY, 1'b0);
    check("rel_edge1_arready", ARREADY, 1'b0);
    tick();
    check("rel_edge2_awready", AWREADY, 1'b1);
    check("rel_edge2_wready", WREADY, 1'b1);
    check("rel_edge2_arready", ARREADY, 1'b1);

    // Directed vector table.
    hw_in[15*DW +: DW] = 32'h5A5A5A5A;
    for (int i = 0; i < 15; i++) hw_in[i*DW +: DW] = $urandom;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, m_resp, m_pulse);
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp, pulse);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_pulse", i), pulse, vecs[i].exp_pulse);
      end else begin
        do_read(vecs[i].addr, 0, rdata, resp);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      end
    end
    check_reg_out("table");

    // W three cycles ahead of AW, then W after AW.
    model_write(12'h008, 32'hCAFEBABE, 4'hF, m_resp, m_pulse);
    do_write(12'h008, 32'hCAFEBABE, 4'hF, 3, 0, 0, resp, pulse);
    check("w_first_bresp", resp, OKAY);
    check("w_first_pulse", pulse, 16'h0004);
    tick();
    check("w_first_single_b", BVALID, 1'b0);
    do_read(12'h008, 0, rdata, resp);
    check("w_first_rdata", rdata, 32'hCAFEBABE);
    model_write(12'h018, 32'h13579BDF, 4'hF, m_resp, m_pulse);
    do_write(12'h018, 32'h13579BDF, 4'hF, 0, 2, 0, resp, pulse);
    check("aw_first_pulse", pulse, 16'h0040);
    check_reg_out("order");

    // Backpressure on B and R.
    model_write(12'h014, 32'h0BADF00D, 4'hF, m_resp, m_pulse);
    do_write(12'h014, 32'h0BADF00D, 4'hF, 0, 0, 5, resp, pulse);
    check("stall_bresp", resp, OKAY);
    do_read(12'h014, 5, rdata, resp);
    check("stall_rdata", rdata, 32'h0BADF00D);
    check("stall_rresp", resp, OKAY);

    // Read and write to the same register committed on the same edge.
    AWADDR = 12'h008; WDATA = 32'h01020304; WSTRB = 4'hF; ARADDR = 12'h008;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("same_edge_bvalid", BVALID, 1'b1);
    check("same_edge_rvalid", RVALID, 1'b1);
    check("same_edge_prewrite", RDATA, model_regs[2]);
    model_write(12'h008, 32'h01020304, 4'hF, m_resp, m_pulse);
    check("same_edge_reg_out", reg_out[2*DW +: DW], model_regs[2]);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    check("same_edge_b_release", BVALID, 1'b0);
    check("same_edge_r_release", RVALID, 1'b0);

    // Reset between the AW and W handshakes.
    AWADDR = 12'h004; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("midrst_got_aw", AWREADY, 1'b0);
    WDATA = 32'h99999999; WSTRB = 4'hF;
    #2;
    ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    check_idle_outputs("midrst");
    check_reg_out("midrst");
    tick();
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    check_idle_outputs("midrst_edge1");
    tick();
    check("midrst_edge2_awready", AWREADY, 1'b1);
    check("midrst_edge2_bvalid", BVALID, 1'b0);
    for (int i = 0; i < NR; i++) begin
      model_read(12'(4 * i), m_data, m_resp);
      do_read(12'(4 * i), 0, rdata, resp);
      check($sformatf("midrst_read%0d", i), rdata, m_data);
    end

    // Random traffic against the reference model.
    for (int t = 0; t < 160; t++) begin
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      addr = 12'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        model_write(addr, data, strb, m_resp, m_pulse);
        do_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), resp, pulse);
        check($sformatf("rnd%0d_bresp", t), resp, m_resp);
        check($sformatf("rnd%0d_pulse", t), pulse, m_pulse);
        check_reg_out($sformatf("rnd%0d", t));
      end else begin
        for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = $urandom;
        model_read(addr, m_data, m_resp);
        do_read(addr, $urandom_range(0, 2), rdata, resp);
        check($sformatf("rnd%0d_rresp", t), resp, m_resp);
        check($sformatf("rnd%0d_rdata", t), rdata, m_data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
